// File: rtl/instr_encoder.sv
// RV32I lw/sw/beq instruction encoder with immediate legality checking and a
// small valid/ready output FIFO; illegal requests become a flagged NOP.
module instr_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] BR_MIN    = -32'sd4096;
    localparam logic signed [31:0] BR_MAX    = 32'sd4094;

    logic [31:0]      instr_mem_q [FIFO_DEPTH];
    logic             err_mem_q   [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;

    logic        imm_legal;
    logic [31:0] enc_word;
    logic [31:0] entry_instr;
    logic        entry_err;
    logic        push, pop;

    always_comb begin
        imm_legal = 1'b0;
        enc_word  = NOP;
        case (in_fmt)
            2'd0: begin
                imm_legal = ($signed(in_imm) >= IMM12_MIN) && ($signed(in_imm) <= IMM12_MAX);
                enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            end
            2'd1: begin
                imm_legal = ($signed(in_imm) >= IMM12_MIN) && ($signed(in_imm) <= IMM12_MAX);
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            end
            2'd2: begin
                imm_legal = ($signed(in_imm) >= BR_MIN) && ($signed(in_imm) <= BR_MAX) && !in_imm[0];
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                             in_imm[4:1], in_imm[11], 7'b1100011};
            end
            default: begin
                imm_legal = 1'b0;
                enc_word  = NOP;
            end
        endcase
        entry_instr = imm_legal ? enc_word : NOP;
        entry_err   = !imm_legal;
    end

    // Ready comes from a register so it never depends on out_ready in the same cycle.
    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                err_mem_q[i]   <= 1'b0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            enc_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (push) begin
                instr_mem_q[wr_ptr_q] <= entry_instr;
                err_mem_q[wr_ptr_q]   <= entry_err;
                enc_cnt_q             <= enc_cnt_q + CNT_W'(1);
                if (entry_err) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= (count_d < DEPTH_C);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_err   = err_mem_q[rd_ptr_q];
    assign enc_cnt   = enc_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
